// File: rtl/mealy_seq_detector_1010_pkg.sv
// ----------------------------------------------------------------------------
// mealy_seq_detector_1010_pkg
//   Shared types and constants for the 1010 serial pattern detector.
//   - state_t : 2-bit FSM state encoding (S_IDLE=0, S_1=1, S_10=2, S_101=3)
//   - PATTERN : the detected sequence, MSB is the first bit received
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

package mealy_seq_detector_1010_pkg;

  // Each state names the longest useful prefix of PATTERN seen so far.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_1    = 2'd1,
    S_10   = 2'd2,
    S_101  = 2'd3
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1010;

endpackage : mealy_seq_detector_1010_pkg

// File: rtl/mealy_seq_detector_1010.sv
// ----------------------------------------------------------------------------
// mealy_seq_detector_1010
//   Mealy FSM that flags the serial sequence 1-0-1-0 (first bit first).
//   One bit is consumed on every rising clock edge; z is combinational from
//   the state register and the bit currently presented on x.
//
// Parameters
//   OVERLAP : 1 = a match's trailing "10" seeds the next match
//             0 = return to idle after every match
//
// Ports
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset (forces S_IDLE)
//   x     in  serial data bit
//   z     out match flag, high while state plus x completes 1010
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module mealy_seq_detector_1010
  import mealy_seq_detector_1010_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  output logic z
);

  state_t state_q;
  state_t state_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d is assigned a default before the case so every path drives
  // it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = x ? S_1 : S_IDLE;
      S_1:    state_d = x ? S_1 : S_10;
      // "100" shares no prefix with 1010, so fall all the way back.
      S_10:   state_d = x ? S_101 : S_IDLE;
      // On the completing 0 the tail "10" is itself a valid prefix; keeping
      // it is what makes detection overlapping.
      S_101: begin
        if (x) begin
          state_d = S_1;
        end else begin
          state_d = OVERLAP ? S_10 : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Mealy output: zero latency relative to the fourth pattern bit, so it
  // follows x within the cycle and is only meaningful at the sampling edge.
  assign z = (state_q == S_101) && !x;

endmodule : mealy_seq_detector_1010

// File: tb/tb_mealy_seq_detector_1010.sv
// ----------------------------------------------------------------------------
// tb_mealy_seq_detector_1010
//   Drives one serial stream into an overlapping and a non-overlapping
//   instance. A shift-register reference model pushes the expected z of each
//   instance when a bit is driven; the value is popped and compared just
//   before the edge that consumes that bit.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mealy_seq_detector_1010;
  import mealy_seq_detector_1010_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x = 1'b0;
  logic z_ov;
  logic z_no;

  int tests = 0;
  int fails = 0;

  // Scoreboards, index 0 = overlapping instance, 1 = non-overlapping.
  logic q_ov[$];
  logic q_no[$];

  // Reference model: last three bits and how many of them are valid since
  // the last reset (or the last match when non-overlapping).
  logic [2:0] m_hist[2];
  int         m_cnt[2];

  logic z_ov_s;
  logic z_no_s;
  bit   release_pending = 1'b0;

  always #5 clk = ~clk;

  mealy_seq_detector_1010 #(.OVERLAP(1'b1)) dut_ov (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x),
    .z    (z_ov)
  );

  mealy_seq_detector_1010 #(.OVERLAP(1'b0)) dut_no (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x),
    .z    (z_no)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_match(input int k, input logic b);
    logic [3:0] seq;
    seq = {m_hist[k], b};
    return rst_n && (m_cnt[k] >= 3) && (seq == PATTERN);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hist[k] = 3'b000;
      m_cnt[k]  = 0;
    end
  endtask

  // Mirrors what one rising edge does to the model.
  task automatic model_step(input logic b);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_cnt[k] = 0;
      end else if (k == 1 && model_match(k, b)) begin
        m_cnt[k] = 0;
      end else begin
        m_hist[k] = {m_hist[k][1:0], b};
        if (m_cnt[k] < 3) m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  task automatic send_bit(input logic b, input string tag);
    logic e_ov;
    logic e_no;
    @(negedge clk);
    if (release_pending) begin
      rst_n = 1'b1;
      release_pending = 1'b0;
    end
    x = b;
    q_ov.push_back(model_match(0, b));
    q_no.push_back(model_match(1, b));
    #2;
    e_ov = q_ov.pop_front();
    e_no = q_no.pop_front();
    z_ov_s = z_ov;
    z_no_s = z_no;
    check({tag, "/z_ov"}, {15'd0, z_ov}, {15'd0, e_ov});
    check({tag, "/z_no"}, {15'd0, z_no}, {15'd0, e_no});
    model_step(b);
  endtask

  // Holds reset for three bits with x toggling; release happens on the
  // negedge that drives the next bit.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      send_bit(i[0] ? 1'b0 : 1'b1, $sformatf("%s_rst%0d", tag, i));
      check({tag, "/state_ov_rst"}, {14'd0, dut_ov.state_q}, {14'd0, S_IDLE});
      check({tag, "/state_no_rst"}, {14'd0, dut_no.state_q}, {14'd0, S_IDLE});
    end
    release_pending = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [15:0] stream;
    logic [9:0]  near;
    logic [15:0] mask_ov;
    logic [15:0] mask_no;
    int          pulses;

    model_reset();

    // Reset held with x toggling.
    apply_reset("reset");

    // Basic match: z only on the fourth bit.
    send_bit(1'b1, "basic1");
    send_bit(1'b0, "basic2");
    send_bit(1'b1, "basic3");
    send_bit(1'b0, "basic4");
    check("basic4/z_ov_direct", {15'd0, z_ov_s}, 16'd1);
    check("basic4/z_no_direct", {15'd0, z_no_s}, 16'd1);

    // Overlap stream, both instances see the same 15 bits.
    apply_reset("ovl");
    stream  = 16'b0110_1010_1110_1010; // bit 14 is sent first
    mask_ov = 16'd0;
    mask_no = 16'd0;
    for (int i = 0; i < 15; i++) begin
      send_bit(stream[14-i], $sformatf("stream_b%0d", i + 1));
      mask_ov[i] = z_ov_s;
      mask_no[i] = z_no_s;
    end
    check("stream/mask_ov", mask_ov, 16'h5050); // bits 5,7,13,15
    check("stream/mask_no", mask_no, 16'h1010); // bits 5,13

    // Near miss: nothing may fire.
    apply_reset("near");
    near   = 10'b10_0101_1011;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      send_bit(near[9-i], $sformatf("near_b%0d", i + 1));
      pulses += int'(z_ov_s) + int'(z_no_s);
    end
    check("near/pulses", pulses[15:0], 16'd0);

    // Reset mid-operation, asserted between clock edges.
    apply_reset("mid");
    send_bit(1'b1, "mid1");
    send_bit(1'b0, "mid2");
    send_bit(1'b1, "mid3");
    @(negedge clk);
    x = 1'b0;
    #1;
    check("mid/z_ov_pre", {15'd0, z_ov}, 16'd1);
    check("mid/z_no_pre", {15'd0, z_no}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("mid/z_ov_async", {15'd0, z_ov}, 16'd0);
    check("mid/z_no_async", {15'd0, z_no}, 16'd0);
    check("mid/state_ov_async", {14'd0, dut_ov.state_q}, {14'd0, S_IDLE});
    check("mid/state_no_async", {14'd0, dut_no.state_q}, {14'd0, S_IDLE});
    #1;
    rst_n = 1'b1;
    model_reset();
    model_step(1'b0); // the coming edge consumes x=0 from idle
    send_bit(1'b0, "mid_after0");
    check("mid_after0/z_ov_direct", {15'd0, z_ov_s}, 16'd0);
    send_bit(1'b1, "mid_re1");
    send_bit(1'b0, "mid_re2");
    send_bit(1'b1, "mid_re3");
    send_bit(1'b0, "mid_re4");
    check("mid_re4/z_ov_direct", {15'd0, z_ov_s}, 16'd1);
    check("mid_re4/z_no_direct", {15'd0, z_no_s}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mealy_seq_detector_1010
